// File: rtl/dcache_pkg.sv
// ==== dcache_pkg: shared types and address-field helpers for the data cache == rev 1.0 ====
`default_nettype none

package dcache_pkg;

  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    DONE      = 2'd3
  } state_e;

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int idx_w);
    return (a >> OFFSET_W) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int idx_w);
    return a >> (OFFSET_W + idx_w);
  endfunction

  function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] a);
    return a[OFFSET_W-1:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_data_array.sv
// ==== dcache_data_array: SETS x LINE_W line storage, async read, line or word write == rev 1.0 ====
`default_nettype none

module dcache_data_array
  import dcache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int LINE_W = LINE_W_DEF,
  parameter int IDX_W  = $clog2(SETS)
) (
  input  logic                  clk_i,
  input  logic [IDX_W-1:0]      idx_i,
  output logic [LINE_W-1:0]     rline_o,
  input  logic                  fill_we_i,
  input  logic [LINE_W-1:0]     fill_line_i,
  input  logic                  word_we_i,
  input  logic [WORD_SEL_W-1:0] word_sel_i,
  input  logic [31:0]           word_i
);

  logic [LINE_W-1:0] mem_q [SETS];

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      mem_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      mem_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_i;
    end
  end

  assign rline_o = mem_q[idx_i];

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
// ==== dcache_controller: direct-mapped write-back/write-allocate D-cache for the MEM stage == rev 1.0 ====
`default_nettype none

module dcache_controller
  import dcache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              Miss_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFFSET_W;

  state_e            state_q;
  logic [SETS-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]  tag_q [SETS];
  logic              mem_req_q, mem_we_q;
  logic [31:0]       mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [WORD_SEL_W-1:0] wsel;
  logic [LINE_W-1:0]     line_rd;
  logic                  req, hit, serve, word_we, fill_we;

  assign idx  = IDX_W'(addr_idx(addr_i, IDX_W));
  assign tag  = TAG_W'(addr_tag(addr_i, IDX_W));
  assign wsel = addr_word(addr_i);
  assign req  = MemRead_i | MemWrite_i;
  assign hit  = valid_q[idx] && (tag_q[idx] == tag);

  // DONE behaves as a hit on the freshly filled line, so both states share the access path.
  assign serve   = ((state_q == IDLE) || (state_q == DONE)) && hit;
  assign word_we = serve && MemWrite_i;
  assign fill_we = (state_q == ALLOCATE) && mem_ack_i;

  assign rdata_o      = (serve && MemRead_i && !MemWrite_i) ? line_rd[{wsel, 5'b0} +: 32] : 32'd0;
  assign Miss_stall_o = (state_q == WRITEBACK) || (state_q == ALLOCATE) ||
                        ((state_q == IDLE) && req && !hit);

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  dcache_data_array #(
    .SETS   (SETS),
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_data (
    .clk_i       (clk_i),
    .idx_i       (idx),
    .rline_o     (line_rd),
    .fill_we_i   (fill_we),
    .fill_line_i (mem_rdata_i),
    .word_we_i   (word_we),
    .word_sel_i  (wsel),
    .word_i      (wdata_i)
  );

  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      tag_q[idx] <= tag;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            mem_req_q <= 1'b1;
            if (valid_q[idx] && dirty_q[idx]) begin
              state_q     <= WRITEBACK;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx, 5'b0};
              mem_wdata_q <= line_rd;
            end else begin
              state_q    <= ALLOCATE;
              mem_we_q   <= 1'b0;
              mem_addr_q <= {tag, idx, 5'b0};
            end
          end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          // Request stays up and turns directly into the fill of the missing line.
          if (mem_ack_i) begin
            state_q    <= ALLOCATE;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {tag, idx, 5'b0};
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state_q      <= DONE;
            mem_req_q    <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          if (word_we) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
